axis_wr_bank: RTL and testbench
===============================

Name: axis_wr_bank

Overview:
Parametrised multi-axis MCU write register bank. One instance replaces the per-axis command register blocks in the motor controller. It decodes a byte-wide MCU write (axis index + register index) into per-axis command registers. 16-bit registers are committed atomically through low-byte shadows. It also maintains per-axis speed-update and position-update request flags, each with a done handshake from the axis pulse generators.

Parameters:
NUM_AXES, 8, number of axis channels (1..2**AXIS_W)
AXIS_W, 3, width of axis index field in Addr
PLS_AUTOCLR, 1, 1: AxisPlsCmd byte is a one-cycle pulse per write; 0: AxisPlsCmd holds its value

Ports:
Clk  in  1  system clock, all logic on rising edge
Rst  in  1  synchronous active-high reset
WrEn  in  1  write strobe, one write per cycle when high
Addr  in  AXIS_W+3  {axis index[AXIS_W+2:3], register index[2:0]}
Din  in  8  write data byte
SpeedSetDone  in  NUM_AXES  per-axis ack clearing SpeedSet
PosSetDone  in  NUM_AXES  per-axis ack clearing PosSet
AxisStateCmd  out  NUM_AXES*16  axis n at [16n+15:16n]
AxisPlsCmd  out  NUM_AXES*8  axis n at [8n+7:8n]
SpeedCmd  out  NUM_AXES*8  axis n at [8n+7:8n]
TargetPos  out  NUM_AXES*16  per-axis target position
RefPos  out  NUM_AXES*16  per-axis reference position
SpeedSet  out  NUM_AXES  speed update pending, per axis
PosSet  out  NUM_AXES  target position update pending, per axis
AddrErr  out  1  sticky: write to axis index >= NUM_AXES

Behaviour:
- Synchronous active-high reset (Rst sampled on rising Clk). All outputs, shadow registers and flags reset to 0. Reset overrides every write and handshake in the same cycle.
- A write occurs when WrEn=1 at a rising edge. Addressed state updates at that edge, so it is visible the cycle after WrEn.
- Register map (register index):
  - 0: StateCmd shadow low byte.
  - 1: AxisPlsCmd.
  - 2: SpeedCmd.
  - 3: commits AxisStateCmd = {Din, StateCmd shadow}.
  - 4: TargetPos shadow low byte.
  - 5: commits TargetPos = {Din, shadow}.
  - 6: RefPos shadow low byte.
  - 7: commits RefPos = {Din, shadow}.
- Atomic commit:
  - Low-byte writes (0, 4, 6) only load the shadow; the visible 16-bit output does not change.
  - The high-byte write (3, 5, 7) updates all 16 bits in one edge.
  - Repeated low writes: the last one wins.
  - A high write with no preceding low write uses the current shadow, which is 0 after reset or the last low byte written.
  - The shadow is not cleared by a commit.
- AxisPlsCmd:
  - PLS_AUTOCLR=1: the written byte appears for exactly one cycle, then that axis's byte returns to 0x00. Back-to-back writes to the same axis give consecutive pulses.
  - PLS_AUTOCLR=0: plain holding register.
- SpeedSet[n]:
  - Set on a write to register 2 of axis n, at the same edge SpeedCmd updates.
  - Cleared at the edge where SpeedSetDone[n]=1.
  - If a set and SpeedSetDone[n] occur in the same cycle, set wins (the new speed is not lost).
- PosSet[n]:
  - Set on a commit write (register 5) of axis n.
  - Cleared by PosSetDone[n], with the same set-wins priority.
  - A low-byte write (register 4) does not affect PosSet.
- Done inputs for axes with no pending flag have no effect.
- Out-of-range axis index (>= NUM_AXES): no register, shadow or flag changes; AddrErr becomes 1 and stays set until Rst.
- Axes are fully independent. A write to axis m never alters axis n's shadows, outputs or flags.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive WrEn with random Addr/Din during Rst=1 -> every output 0x0/0 after release; AddrErr=0.
- Atomic commit: axis 3, write reg 4 = 0x34 -> TargetPos[3] unchanged, PosSet[3]=0; then reg 5 = 0x12 -> next cycle TargetPos[3]=0x1234, PosSet[3]=1. Pulse PosSetDone[3] -> PosSet[3]=0. Other axes stay 0.
- Speed handshake collision: SpeedSet[0]=1 pending; in one cycle write reg 2 of axis 0 = 0x80 and assert SpeedSetDone[0] -> SpeedCmd[0]=0x80, SpeedSet[0] stays 1. Then SpeedSetDone[0] alone -> SpeedSet[0]=0.
- Pulse mode (PLS_AUTOCLR=1): write reg 1 of axis 7 = 0xA5 on two consecutive cycles -> AxisPlsCmd[7]=0xA5 for exactly two cycles, then 0x00. With PLS_AUTOCLR=0, 0xA5 holds.
- Address error (NUM_AXES=6, AXIS_W=3): write axis 6 reg 2 = 0xFF -> no output change, no SpeedSet, AddrErr=1. A following valid write works normally and AddrErr remains 1.
- Shadow reuse: axis 1, reg 6 = 0x22, reg 7 = 0x11 -> RefPos[1]=0x1122. Then reg 7 = 0x33 alone -> RefPos[1]=0x3322. Reset mid-sequence between reg 6 and reg 7 -> the next reg 7 = 0x44 gives 0x4400.

Source files
------------

// File: rtl/axis_wr_bank.sv
// Per-axis MCU write register bank: byte writes decoded into 16-bit atomic commands and 8-bit commands, with update flags.
// Latency: a write is visible on the outputs one cycle after WrEn; all outputs are registered.
// Backpressure: none; one write is accepted every cycle WrEn is high, and done handshakes are always accepted.
module axis_wr_bank #(
  parameter int NUM_AXES    = 8,
  parameter int AXIS_W      = 3,
  parameter int PLS_AUTOCLR = 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     WrEn,
  input  logic [AXIS_W+2:0]        Addr,
  input  logic [7:0]               Din,
  input  logic [NUM_AXES-1:0]      SpeedSetDone,
  input  logic [NUM_AXES-1:0]      PosSetDone,
  output logic [NUM_AXES*16-1:0]   AxisStateCmd,
  output logic [NUM_AXES*8-1:0]    AxisPlsCmd,
  output logic [NUM_AXES*8-1:0]    SpeedCmd,
  output logic [NUM_AXES*16-1:0]   TargetPos,
  output logic [NUM_AXES*16-1:0]   RefPos,
  output logic [NUM_AXES-1:0]      SpeedSet,
  output logic [NUM_AXES-1:0]      PosSet,
  output logic                     AddrErr
);

  // Register index map within one axis.
  localparam int REG_STATE_LO = 0;
  localparam int REG_PLS      = 1;
  localparam int REG_SPEED    = 2;
  localparam int REG_STATE_HI = 3;
  localparam int REG_TGT_LO   = 4;
  localparam int REG_TGT_HI   = 5;
  localparam int REG_REF_LO   = 6;
  localparam int REG_REF_HI   = 7;

  // Axis count widened by one bit so the range check also works when every index is legal.
  localparam logic [AXIS_W:0] NUM_AXES_W = (AXIS_W + 1)'(NUM_AXES);

  logic [AXIS_W-1:0] axis_idx;
  logic [2:0]        reg_idx;
  logic              in_range;
  logic              addr_err_q;

  assign axis_idx = Addr[AXIS_W+2:3];
  assign reg_idx  = Addr[2:0];
  assign in_range = ({1'b0, axis_idx} < NUM_AXES_W);

  // Sticky flag for writes aimed at a nonexistent axis; only reset clears it.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      addr_err_q <= 1'b0;
    end else if (WrEn && !in_range) begin
      addr_err_q <= 1'b1;
    end
  end

  assign AddrErr = addr_err_q;

  for (genvar n = 0; n < NUM_AXES; n++) begin : g_axis
    logic       sel;
    logic [7:0] hit;

    logic [7:0]  state_lo_q;
    logic [7:0]  tgt_lo_q;
    logic [7:0]  ref_lo_q;
    logic [15:0] state_cmd_q;
    logic [7:0]  pls_cmd_q;
    logic [7:0]  speed_cmd_q;
    logic [15:0] tgt_pos_q;
    logic [15:0] ref_pos_q;
    logic        speed_set_q;
    logic        pos_set_q;

    // One-hot register strobe for this axis; out-of-range writes never match any axis.
    assign sel = WrEn && in_range && (axis_idx == AXIS_W'(n));
    assign hit = sel ? (8'b1 << reg_idx) : 8'b0;

    // Low-byte shadows; they hold their value across commits so a bare high write reuses them.
    always_ff @(posedge Clk) begin
      if (Rst) begin
        state_lo_q <= 8'h00;
        tgt_lo_q   <= 8'h00;
        ref_lo_q   <= 8'h00;
      end else begin
        if (hit[REG_STATE_LO]) state_lo_q <= Din;
        if (hit[REG_TGT_LO])   tgt_lo_q   <= Din;
        if (hit[REG_REF_LO])   ref_lo_q   <= Din;
      end
    end

    // 16-bit registers update all bits together on the high-byte write.
    always_ff @(posedge Clk) begin
      if (Rst) begin
        state_cmd_q <= 16'h0000;
        tgt_pos_q   <= 16'h0000;
        ref_pos_q   <= 16'h0000;
      end else begin
        if (hit[REG_STATE_HI]) state_cmd_q <= {Din, state_lo_q};
        if (hit[REG_TGT_HI])   tgt_pos_q   <= {Din, tgt_lo_q};
        if (hit[REG_REF_HI])   ref_pos_q   <= {Din, ref_lo_q};
      end
    end

    // Pulse command: either a one-cycle strobe per write or a plain holding register.
    always_ff @(posedge Clk) begin
      if (Rst) begin
        pls_cmd_q <= 8'h00;
      end else if (hit[REG_PLS]) begin
        pls_cmd_q <= Din;
      end else if (PLS_AUTOCLR != 0) begin
        pls_cmd_q <= 8'h00;
      end
    end

    // Speed command byte.
    always_ff @(posedge Clk) begin
      if (Rst) begin
        speed_cmd_q <= 8'h00;
      end else if (hit[REG_SPEED]) begin
        speed_cmd_q <= Din;
      end
    end

    // Update-pending flags; a new request beats a simultaneous done so no update is lost.
    always_ff @(posedge Clk) begin
      if (Rst) begin
        speed_set_q <= 1'b0;
        pos_set_q   <= 1'b0;
      end else begin
        if (hit[REG_SPEED]) begin
          speed_set_q <= 1'b1;
        end else if (SpeedSetDone[n]) begin
          speed_set_q <= 1'b0;
        end
        if (hit[REG_TGT_HI]) begin
          pos_set_q <= 1'b1;
        end else if (PosSetDone[n]) begin
          pos_set_q <= 1'b0;
        end
      end
    end

    assign AxisStateCmd[16*n +: 16] = state_cmd_q;
    assign AxisPlsCmd[8*n +: 8]     = pls_cmd_q;
    assign SpeedCmd[8*n +: 8]       = speed_cmd_q;
    assign TargetPos[16*n +: 16]    = tgt_pos_q;
    assign RefPos[16*n +: 16]       = ref_pos_q;
    assign SpeedSet[n]              = speed_set_q;
    assign PosSet[n]                = pos_set_q;
  end

endmodule

// File: tb/tb_axis_wr_bank.sv
// Directed bench for axis_wr_bank: one default instance (8 axes, pulse auto-clear) and one with 6 axes and held pulse byte.
// Inputs change on the falling edge; outputs are compared on the falling edge after the capturing rising edge.
// No flow control in the design, so every step is a fixed number of cycles.
module tb_axis_wr_bank;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  // Instance A: defaults
  logic         a_wr = 1'b0;
  logic [5:0]   a_addr = '0;
  logic [7:0]   a_din = '0;
  logic [7:0]   a_sdone = '0;
  logic [7:0]   a_pdone = '0;
  logic [127:0] a_state, a_tgt, a_ref;
  logic [63:0]  a_pls, a_speed;
  logic [7:0]   a_sset, a_pset;
  logic         a_err;

  // Instance B: 6 axes, holding pulse register
  logic         b_wr = 1'b0;
  logic [5:0]   b_addr = '0;
  logic [7:0]   b_din = '0;
  logic [5:0]   b_sdone = '0;
  logic [5:0]   b_pdone = '0;
  logic [95:0]  b_state, b_tgt, b_ref;
  logic [47:0]  b_pls, b_speed;
  logic [5:0]   b_sset, b_pset;
  logic         b_err;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  axis_wr_bank u_a (
    .Clk(Clk), .Rst(Rst), .WrEn(a_wr), .Addr(a_addr), .Din(a_din),
    .SpeedSetDone(a_sdone), .PosSetDone(a_pdone),
    .AxisStateCmd(a_state), .AxisPlsCmd(a_pls), .SpeedCmd(a_speed),
    .TargetPos(a_tgt), .RefPos(a_ref), .SpeedSet(a_sset), .PosSet(a_pset),
    .AddrErr(a_err)
  );

  axis_wr_bank #(.NUM_AXES(6), .AXIS_W(3), .PLS_AUTOCLR(0)) u_b (
    .Clk(Clk), .Rst(Rst), .WrEn(b_wr), .Addr(b_addr), .Din(b_din),
    .SpeedSetDone(b_sdone), .PosSetDone(b_pdone),
    .AxisStateCmd(b_state), .AxisPlsCmd(b_pls), .SpeedCmd(b_speed),
    .TargetPos(b_tgt), .RefPos(b_ref), .SpeedSet(b_sset), .PosSet(b_pset),
    .AddrErr(b_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single-cycle write to instance A; returns on the falling edge after the capturing edge.
  task automatic wr_a(input int axis, input int rg, input logic [7:0] d);
    @(negedge Clk);
    a_wr = 1'b1;
    a_addr = {3'(axis), 3'(rg)};
    a_din = d;
    @(negedge Clk);
    a_wr = 1'b0;
  endtask

  task automatic wr_b(input int axis, input int rg, input logic [7:0] d);
    @(negedge Clk);
    b_wr = 1'b1;
    b_addr = {3'(axis), 3'(rg)};
    b_din = d;
    @(negedge Clk);
    b_wr = 1'b0;
  endtask

  initial begin
    // Reset with live random writes on both instances
    Rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      a_wr = 1'b1; a_addr = 6'($urandom); a_din = 8'($urandom);
      b_wr = 1'b1; b_addr = 6'($urandom); b_din = 8'($urandom);
      a_sdone = 8'($urandom); a_pdone = 8'($urandom);
    end
    @(negedge Clk);
    Rst = 1'b0;
    a_wr = 1'b0; b_wr = 1'b0; a_sdone = '0; a_pdone = '0;
    @(negedge Clk);
    chk("rst_state", a_state, 128'h0);
    chk("rst_pls", a_pls, 128'h0);
    chk("rst_speed", a_speed, 128'h0);
    chk("rst_tgt", a_tgt, 128'h0);
    chk("rst_ref", a_ref, 128'h0);
    chk("rst_flags", {a_sset, a_pset}, 128'h0);
    chk("rst_err_a", a_err, 128'h0);
    chk("rst_err_b", b_err, 128'h0);

    // Atomic commit of TargetPos on axis 3
    wr_a(3, 4, 8'h34);
    chk("tgt_lo_only", a_tgt, 128'h0);
    chk("tgt_lo_noset", a_pset, 128'h0);
    wr_a(3, 5, 8'h12);
    chk("tgt_commit", a_tgt, 128'h1234 << 48);
    chk("pos_set", a_pset, 128'h08);
    a_pdone = 8'h08;
    @(negedge Clk);
    a_pdone = 8'h00;
    chk("pos_done", a_pset, 128'h0);
    chk("tgt_held", a_tgt, 128'h1234 << 48);

    // AxisStateCmd commit on axis 2, untouched by other registers
    wr_a(2, 0, 8'hCD);
    chk("state_lo_only", a_state, 128'h0);
    wr_a(2, 3, 8'hAB);
    chk("state_commit", a_state, 128'hABCD << 32);

    // Speed handshake collision on axis 0
    wr_a(0, 2, 8'h11);
    chk("speed_first", a_speed, 128'h11);
    chk("speed_set", a_sset, 128'h01);
    @(negedge Clk);
    a_wr = 1'b1; a_addr = {3'd0, 3'd2}; a_din = 8'h80; a_sdone = 8'h01;
    @(negedge Clk);
    a_wr = 1'b0; a_sdone = 8'h00;
    chk("speed_collide_cmd", a_speed, 128'h80);
    chk("speed_collide_set", a_sset, 128'h01);
    a_sdone = 8'h21;
    a_pdone = 8'h40;
    @(negedge Clk);
    a_sdone = 8'h00; a_pdone = 8'h00;
    chk("speed_done", a_sset, 128'h0);
    chk("idle_done_pos", a_pset, 128'h0);

    // Pulse mode: two back-to-back writes to axis 7
    @(negedge Clk);
    a_wr = 1'b1; a_addr = {3'd7, 3'd1}; a_din = 8'hA5;
    @(negedge Clk);
    chk("pls_cyc1", a_pls, 128'hA5 << 56);
    @(negedge Clk);
    a_wr = 1'b0;
    chk("pls_cyc2", a_pls, 128'hA5 << 56);
    @(negedge Clk);
    chk("pls_clear", a_pls, 128'h0);

    // Shadow reuse on RefPos axis 1
    wr_a(1, 6, 8'h22);
    chk("ref_lo_only", a_ref, 128'h0);
    wr_a(1, 7, 8'h11);
    chk("ref_commit", a_ref, 128'h1122 << 16);
    wr_a(1, 7, 8'h33);
    chk("ref_reuse", a_ref, 128'h3322 << 16);
    wr_a(1, 6, 8'h55);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    wr_a(1, 7, 8'h44);
    chk("ref_after_rst", a_ref, 128'h4400 << 16);
    chk("tgt_after_rst", a_tgt, 128'h0);
    chk("speed_after_rst", a_speed, 128'h0);
    chk("err_a_never", a_err, 128'h0);

    // Instance B: out-of-range axis then a valid write
    wr_b(6, 2, 8'hFF);
    chk("oor_speed", b_speed, 128'h0);
    chk("oor_sset", b_sset, 128'h0);
    chk("oor_err", b_err, 128'h1);
    wr_b(7, 5, 8'h99);
    chk("oor_tgt", b_tgt, 128'h0);
    chk("oor_pset", b_pset, 128'h0);
    wr_b(2, 2, 8'h07);
    chk("valid_speed", b_speed, 128'h07 << 16);
    chk("valid_sset", b_sset, 128'h04);
    chk("err_sticky", b_err, 128'h1);

    // Instance B: held pulse byte
    wr_b(4, 1, 8'hA5);
    chk("hold_cyc1", b_pls, 128'hA5 << 32);
    @(negedge Clk);
    @(negedge Clk);
    chk("hold_cyc3", b_pls, 128'hA5 << 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
